// File: rtl/shift_reservation_station.sv
// rtl/shift_reservation_station.sv - collapsing, age-ordered reservation station for the shift unit
module shift_reservation_station #(
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSsize     = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  dispatchValid_i,
  input  logic [9:0]            dispatchCommands_i,
  input  logic [ROBsizeLog-1:0] dispatchTag_i,
  input  logic [63:0]           dispatchVal1_i,
  input  logic [63:0]           dispatchVal2_i,
  input  logic                  dispatchReady1_i,
  input  logic                  dispatchReady2_i,
  input  logic [ROBsizeLog-1:0] dispatchSrcTag1_i,
  input  logic [ROBsizeLog-1:0] dispatchSrcTag2_i,
  output logic                  rsFull_o,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [63:0]           cdbVal_i,
  output logic                  readyRS_o,
  output logic [63:0]           reservationStationVal1_o,
  output logic [63:0]           reservationStationVal2_o,
  output logic [9:0]            reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o,
  input  logic                  stallRS_i
);

  localparam int CW = $clog2(RSsize + 1);
  localparam int IW = $clog2(RSsize);

  typedef struct packed {
    logic                  valid;
    logic [9:0]            cmd;
    logic [ROBsizeLog-1:0] tag;
    logic [63:0]           val1;
    logic [63:0]           val2;
    logic                  rdy1;
    logic                  rdy2;
    logic [ROBsizeLog-1:0] src1;
    logic [ROBsizeLog-1:0] src2;
  } entry_t;

  entry_t          ent_q [RSsize];
  entry_t          ent_d [RSsize];
  entry_t          woken [RSsize+1];
  entry_t          new_ent;
  logic [CW-1:0]   count_q, count_d, count_after;
  logic            full_q;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic            xfer, accept;

  // Select works purely on registered state so stallRS_i may depend on readyRS_o.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < RSsize; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign readyRS_o                    = sel_found;
  assign reservationStationVal1_o     = sel_found ? ent_q[sel_idx].val1 : 64'd0;
  assign reservationStationVal2_o     = sel_found ? ent_q[sel_idx].val2 : 64'd0;
  assign reservationStationCommands_o = sel_found ? ent_q[sel_idx].cmd  : 10'd0;
  assign reservationStationTag_o      = sel_found ? ent_q[sel_idx].tag  : '0;
  assign rsFull_o                     = full_q;

  assign xfer        = sel_found & ~stallRS_i;
  assign accept      = dispatchValid_i & ~full_q;
  assign count_after = count_q - CW'(xfer);
  assign count_d     = count_after + CW'(accept);

  always_comb begin
    for (int i = 0; i < RSsize; i++) begin
      woken[i] = ent_q[i];
      if (cdbValid_i && ent_q[i].valid && !ent_q[i].rdy1 && ent_q[i].src1 == cdbTag_i) begin
        woken[i].val1 = cdbVal_i;
        woken[i].rdy1 = 1'b1;
      end
      if (cdbValid_i && ent_q[i].valid && !ent_q[i].rdy2 && ent_q[i].src2 == cdbTag_i) begin
        woken[i].val2 = cdbVal_i;
        woken[i].rdy2 = 1'b1;
      end
    end
    woken[RSsize] = '0;
  end

  // Same-cycle CDB bypass for operands that arrive not ready.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.cmd   = dispatchCommands_i;
    new_ent.tag   = dispatchTag_i;
    new_ent.val1  = dispatchVal1_i;
    new_ent.val2  = dispatchVal2_i;
    new_ent.rdy1  = dispatchReady1_i;
    new_ent.rdy2  = dispatchReady2_i;
    new_ent.src1  = dispatchSrcTag1_i;
    new_ent.src2  = dispatchSrcTag2_i;
    if (!dispatchReady1_i && cdbValid_i && cdbTag_i == dispatchSrcTag1_i) begin
      new_ent.val1 = cdbVal_i;
      new_ent.rdy1 = 1'b1;
    end
    if (!dispatchReady2_i && cdbValid_i && cdbTag_i == dispatchSrcTag2_i) begin
      new_ent.val2 = cdbVal_i;
      new_ent.rdy2 = 1'b1;
    end
  end

  // Collapse above the issued slot, then append the dispatch behind the survivors.
  always_comb begin
    for (int i = 0; i < RSsize; i++) begin
      if (xfer && i >= int'(sel_idx)) ent_d[i] = woken[i+1];
      else                            ent_d[i] = woken[i];
      if (accept && CW'(i) == count_after) ent_d[i] = new_ent;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int i = 0; i < RSsize; i++) ent_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < RSsize; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
      full_q  <= (count_d == CW'(RSsize));
    end
  end

endmodule

// File: tb/tb_shift_reservation_station.sv
// tb/tb_shift_reservation_station.sv - directed self-checking bench for shift_reservation_station
module tb_shift_reservation_station;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, flush_i = 1'b0;
  logic        dispatchValid_i = 1'b0;
  logic [9:0]  dispatchCommands_i = '0;
  logic [4:0]  dispatchTag_i = '0, dispatchSrcTag1_i = '0, dispatchSrcTag2_i = '0;
  logic [63:0] dispatchVal1_i = '0, dispatchVal2_i = '0;
  logic        dispatchReady1_i = 1'b0, dispatchReady2_i = 1'b0;
  logic        rsFull_o;
  logic        cdbValid_i = 1'b0;
  logic [4:0]  cdbTag_i = '0;
  logic [63:0] cdbVal_i = '0;
  logic        readyRS_o;
  logic [63:0] reservationStationVal1_o, reservationStationVal2_o;
  logic [9:0]  reservationStationCommands_o;
  logic [4:0]  reservationStationTag_o;
  logic        stallRS_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  shift_reservation_station dut (
    .clk_i                        (clk),
    .reset_i                      (reset_i),
    .flush_i                      (flush_i),
    .dispatchValid_i              (dispatchValid_i),
    .dispatchCommands_i           (dispatchCommands_i),
    .dispatchTag_i                (dispatchTag_i),
    .dispatchVal1_i               (dispatchVal1_i),
    .dispatchVal2_i               (dispatchVal2_i),
    .dispatchReady1_i             (dispatchReady1_i),
    .dispatchReady2_i             (dispatchReady2_i),
    .dispatchSrcTag1_i            (dispatchSrcTag1_i),
    .dispatchSrcTag2_i            (dispatchSrcTag2_i),
    .rsFull_o                     (rsFull_o),
    .cdbValid_i                   (cdbValid_i),
    .cdbTag_i                     (cdbTag_i),
    .cdbVal_i                     (cdbVal_i),
    .readyRS_o                    (readyRS_o),
    .reservationStationVal1_o     (reservationStationVal1_o),
    .reservationStationVal2_o     (reservationStationVal2_o),
    .reservationStationCommands_o (reservationStationCommands_o),
    .reservationStationTag_o      (reservationStationTag_o),
    .stallRS_i                    (stallRS_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] tag, input logic [63:0] v1, input logic [63:0] v2,
                      input logic r1, input logic r2, input logic [4:0] s1, input logic [4:0] s2);
    dispatchValid_i    = 1'b1;
    dispatchCommands_i = 10'h080;
    dispatchTag_i      = tag;
    dispatchVal1_i     = v1;
    dispatchVal2_i     = v2;
    dispatchReady1_i   = r1;
    dispatchReady2_i   = r2;
    dispatchSrcTag1_i  = s1;
    dispatchSrcTag2_i  = s2;
  endtask

  task automatic cdb(input logic v, input logic [4:0] tag, input logic [63:0] val);
    cdbValid_i = v;
    cdbTag_i   = tag;
    cdbVal_i   = val;
  endtask

  initial begin
    tick(); tick();
    reset_i = 1'b0;
    check("rst_ready", readyRS_o, 0);
    check("rst_full", rsFull_o, 0);
    check("rst_val1", reservationStationVal1_o, 0);
    check("rst_tag", reservationStationTag_o, 0);

    // Both operands ready: visible next cycle, issued and gone the one after.
    disp(3, 64'h0F, 64'd4, 1, 1, 0, 0);
    tick(); dispatchValid_i = 1'b0;
    check("t1_ready", readyRS_o, 1);
    check("t1_val1", reservationStationVal1_o, 64'h0F);
    check("t1_val2", reservationStationVal2_o, 64'd4);
    check("t1_tag", reservationStationTag_o, 3);
    check("t1_cmd", reservationStationCommands_o, 10'h080);
    tick();
    check("t1_gone", readyRS_o, 0);

    // Operand 2 waits for tag 7; tag 6 must not wake it.
    disp(10, 64'd1, 64'd0, 1, 0, 0, 7);
    tick(); dispatchValid_i = 1'b0;
    check("t2_pending", readyRS_o, 0);
    cdb(1, 6, 64'd99);
    tick();
    check("t2_wrongtag", readyRS_o, 0);
    cdb(1, 7, 64'd8);
    tick(); cdb(0, 0, 0);
    check("t2_ready", readyRS_o, 1);
    check("t2_val2", reservationStationVal2_o, 64'd8);
    check("t2_tag", reservationStationTag_o, 10);
    tick();
    check("t2_gone", readyRS_o, 0);

    // Same-cycle CDB bypass at dispatch.
    disp(11, 64'd0, 64'd2, 0, 1, 5, 0);
    cdb(1, 5, 64'hAA);
    tick(); dispatchValid_i = 1'b0; cdb(0, 0, 0);
    check("t3_ready", readyRS_o, 1);
    check("t3_val1", reservationStationVal1_o, 64'hAA);
    tick();
    check("t3_gone", readyRS_o, 0);

    // Fill the station; tags 2 and 3 share producer 12.
    disp(1, 0, 64'd1, 0, 1, 13, 0); tick();
    disp(2, 0, 64'd1, 0, 1, 12, 0); tick();
    disp(3, 0, 64'd1, 0, 1, 12, 0); tick();
    disp(4, 0, 64'd1, 0, 1, 14, 0); tick();
    check("t4_full", rsFull_o, 1);
    check("t4_noready", readyRS_o, 0);
    disp(9, 64'd5, 64'd6, 1, 1, 0, 0);
    tick(); dispatchValid_i = 1'b0;
    check("t4_ignored_full", rsFull_o, 1);
    check("t4_ignored_rdy", readyRS_o, 0);
    cdb(1, 12, 64'h55);
    tick(); cdb(0, 0, 0);
    check("t4_first_rdy", readyRS_o, 1);
    check("t4_first_tag", reservationStationTag_o, 2);
    check("t4_first_val1", reservationStationVal1_o, 64'h55);
    check("t4_full_still", rsFull_o, 1);
    tick();
    check("t4_second_tag", reservationStationTag_o, 3);
    check("t4_full_drop", rsFull_o, 0);
    tick();
    check("t4_drained", readyRS_o, 0);

    // Stall holds tag 4 for three cycles, release issues it.
    cdb(1, 14, 64'h44);
    stallRS_i = 1'b1;
    tick(); cdb(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("t5_stall_rdy", readyRS_o, 1);
      check("t5_stall_tag", reservationStationTag_o, 4);
      if (i < 2) tick();
    end
    stallRS_i = 1'b0;
    tick();
    check("t5_removed", readyRS_o, 0);

    // Three entries (tag 1 still pending on 13) then flush with a dispatch.
    disp(20, 0, 64'd1, 0, 1, 15, 0); tick();
    disp(21, 0, 64'd1, 0, 1, 15, 0); tick();
    disp(22, 64'd3, 64'd3, 1, 1, 0, 0);
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; dispatchValid_i = 1'b0;
    check("t6_flush_rdy", readyRS_o, 0);
    check("t6_flush_full", rsFull_o, 0);
    cdb(1, 13, 64'd1); tick();
    cdb(1, 15, 64'd1); tick(); cdb(0, 0, 0);
    check("t6_empty", readyRS_o, 0);

    // Reset while a ready entry is stalled.
    disp(25, 64'h77, 64'd1, 1, 1, 0, 0);
    tick(); dispatchValid_i = 1'b0; stallRS_i = 1'b1;
    check("t7_ready", readyRS_o, 1);
    reset_i = 1'b1;
    tick(); reset_i = 1'b0; stallRS_i = 1'b0;
    check("t7_rst_rdy", readyRS_o, 0);
    check("t7_rst_val1", reservationStationVal1_o, 0);
    check("t7_rst_tag", reservationStationTag_o, 0);
    check("t7_rst_full", rsFull_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reservation_station.md
# shift_reservation_station

Reservation station feeding the shift execution unit. Accepts dispatched shift instructions, holds up to `RSsize` of them, and snoops the common data bus (CDB) to capture pending source operands. Each cycle it presents the oldest fully-ready entry to the shift issue/execute stage over the `readyRS`/`stallRS` handshake, and removes the entry on transfer. It sits between dispatch/rename and the shift issue/execute stage.

## Interface
- `ROBsize`, 16, number of ROB entries.
- `ROBsizeLog`, `$clog2(ROBsize+1)`, tag width.
- `RSsize`, 4, number of station entries (≥2).

- `clk_i`  in  1  clock; all state updates on posedge.
- `reset_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous clear of all entries (mispredict recovery).
- `dispatchValid_i`  in  1  new instruction present this cycle.
- `dispatchCommands_i`  in  10  opaque command bits; bit 7 = shift left.
- `dispatchTag_i`  in  ROBsizeLog  destination ROB tag.
- `dispatchVal1_i`, `dispatchVal2_i`  in  64 each  operand values, meaningful when the matching ready bit is 1.
- `dispatchReady1_i`, `dispatchReady2_i`  in  1 each  operand already available.
- `dispatchSrcTag1_i`, `dispatchSrcTag2_i`  in  ROBsizeLog each  producer tag when not ready.
- `rsFull_o`  out  1  all entries occupied; dispatch must be held off.
- `cdbValid_i`  in  1  CDB broadcast valid.
- `cdbTag_i`  in  ROBsizeLog  broadcast producer tag.
- `cdbVal_i`  in  64  broadcast value.
- `readyRS_o`  out  1  issue payload valid.
- `reservationStationVal1_o`, `reservationStationVal2_o`  out  64 each  operands of the selected entry.
- `reservationStationCommands_o`  out  10  commands of the selected entry.
- `reservationStationTag_o`  out  ROBsizeLog  destination tag of the selected entry.
- `stallRS_i`  in  1  execute stage cannot accept.

## Operation
- Storage is a collapsing, age-ordered queue. Entry 0 is the oldest. Each entry holds valid, commands, tag, val1/2, rdy1/2, srcTag1/2.
- **Dispatch.** Accepted when `dispatchValid_i & ~rsFull_o`. The new entry is written at the first free slot after collapse. `dispatchValid_i` while `rsFull_o` is 1 is ignored, with no state change.
- **Dispatch bypass.** If an operand is not ready and `cdbValid_i` with `cdbTag_i == srcTag` in the same cycle, the operand is stored as ready with `cdbVal_i`.
- **Wakeup.** Each valid entry with a not-ready operand whose srcTag equals `cdbTag_i` while `cdbValid_i` is 1 captures `cdbVal_i` and sets rdy. Both operands may wake on the same broadcast.
- **Select.** The selected entry is the lowest-index valid entry with rdy1 & rdy2. `readyRS_o` is 1 iff such an entry exists. The payload outputs come from that entry, or are all-zero when none exists.
- **Transfer.** Occurs in a cycle with `readyRS_o & ~stallRS_i`. The selected entry is removed at the clock edge, and younger entries shift down one slot. Same-cycle dispatch lands behind the shifted entries.
- **Stall.** While `stallRS_i` is 1, no entry is removed. The payload may change only if an older entry becomes ready; the oldest-ready rule always holds.
- **Combinational path.** `readyRS_o` and the payload are functions of registered state only, never of `stallRS_i` or the CDB inputs in the same cycle. This is mandatory because the execute stage derives `stallRS_i` combinationally from `readyRS_o`.
- **Full flag.** `rsFull_o` is registered: 1 iff the occupancy count equals `RSsize`.
- **Flush.** `flush_i` invalidates all entries. It has priority over dispatch, wakeup and transfer in that cycle.

## Timing
- **Reset.** All entries invalid. `readyRS_o`=0, `rsFull_o`=0, all payload outputs = 0, starting the cycle after `reset_i` is sampled high. `reset_i` takes priority over `flush_i`. Reset mid-operation drops all held instructions.
- **Dispatch-to-ready latency.** Dispatch with both operands ready in cycle N gives `readyRS_o`=1 in N+1. Minimum residency is 1 cycle.
- **Wakeup latency.** A CDB match in cycle N gives ready in N+1. Dispatch bypass also gives ready in N+1.
- **Removal.** Transfer in cycle N means the entry is gone in N+1. Back-to-back issue of one entry per cycle is supported when `stallRS_i`=0.
- **Full flag update.** `rsFull_o` updates one cycle after the count change. Transfer and dispatch in the same cycle keep the count unchanged.
- **Flush.** `flush_i` in cycle N gives `readyRS_o`=0 and `rsFull_o`=0 in N+1.

## Test plan
- Reset, then in cycle 0 dispatch `Val1`=0x0F, `Val2`=4, tag=3, both operands ready, `stallRS_i`=0 → `readyRS_o`=1 in cycle 1 with that payload; `readyRS_o`=0 in cycle 2.
- Dispatch with `Val2` pending on srcTag 7; CDB broadcasts tag 7, value 8 in cycle 3 → `readyRS_o`=1 in cycle 4 with `reservationStationVal2_o`=8. CDB tag 6 causes no wakeup.
- Dispatch with srcTag1=5 while the CDB broadcasts tag 5, value 0xAA in the same cycle → ready next cycle with `Val1`=0xAA.
- Dispatch 4 entries (tags 1-4), all pending → `rsFull_o`=1. A 5th dispatch (tag 9) is ignored. Wake tags 3 and 2 together → tag 2 issues first, then tag 3. `rsFull_o` drops one cycle after the first transfer.
- Ready entry with `stallRS_i` held high for 3 cycles → entry retained and `readyRS_o` stays 1. Release the stall → one transfer, then removal.
- 3 valid entries and `flush_i` pulsed together with a dispatch → all empty next cycle and the dispatch is discarded. `reset_i` asserted mid-stall → all outputs 0 next cycle.
